pipe_lsu: RTL and testbench

//  Parametrised load/store unit for the MEM stage of the pipelined core.

---
 rtl/pipe_lsu_pkg.sv | 19 +
 rtl/pipe_lsu_lane_align.sv | 44 ++++
 rtl/pipe_lsu.sv | 205 ++++++++++++++++++++
 tb/tb_pipe_lsu.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_lsu_pkg.sv
// rtl/pipe_lsu_pkg.sv - shared LSU types: FSM states, access sizes, funct3 codes
package pipe_lsu_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, ACCESS2} lsu_state_t;
  typedef enum logic [1:0] {MS_B, MS_H, MS_W, MS_D} mem_size_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

endpackage

// File: rtl/pipe_lsu_lane_align.sv
// rtl/pipe_lsu_lane_align.sv - combinational byte-lane placement (store) and extract/extend (load)
// Store side works over a two-beat window so a beat-crossing store yields both halves.
module pipe_lsu_lane_align
  import pipe_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OFFW = $clog2(XLEN / 8)
) (
  input  logic [OFFW-1:0]        off,
  input  mem_size_t              size,
  input  logic                   uns,
  input  logic [XLEN-1:0]        st_data,
  output logic [2*XLEN-1:0]      st_wide,
  output logic [2*(XLEN/8)-1:0]  st_mbe,
  input  logic [2*XLEN-1:0]      ld_wide,
  output logic [XLEN-1:0]        ld_data
);

  localparam int NBYTES = XLEN / 8;

  logic [2*NBYTES-1:0] base;
  logic [XLEN-1:0]     shifted;
  logic                sign;
  int                  nbits;

  always_comb begin
    st_wide = {{XLEN{1'b0}}, st_data} << {off, 3'b000};
    base = '0;
    for (int i = 0; i < NBYTES; i++) base[i] = (i < (1 << int'(size)));
    st_mbe = base << off;

    shifted = XLEN'(ld_wide >> {off, 3'b000});
    nbits = 8 << int'(size);
    case (size)
      MS_B:    sign = shifted[7];
      MS_H:    sign = shifted[15];
      MS_W:    sign = shifted[31];
      default: sign = shifted[XLEN-1];
    endcase
    sign = sign & ~uns;
    for (int i = 0; i < XLEN; i++) ld_data[i] = (i < nbits) ? shifted[i] : sign;
  end

endmodule

// File: rtl/pipe_lsu.sv
// rtl/pipe_lsu.sv - MEM-stage load/store unit: req/resp FSM, request latches, split merge
// LSU_MISALIGN_SPLIT_EN: beat-crossing misaligned accesses run as two beats instead of faulting.
module pipe_lsu
  import pipe_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int NBYTES = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [NBYTES-1:0] dmem_mbe,
  input  logic              dmem_resp,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              stall,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              fault
);

  localparam int OFFW = $clog2(NBYTES);
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  lsu_state_t        state_q, state_d;
  logic              req_ready_q, req_ready_d, stall_q, stall_d;
  logic              dmem_read_q, dmem_read_d, dmem_write_q, dmem_write_d;
  logic              wb_valid_q, wb_valid_d, fault_q, fault_d;
  logic [4:0]        wb_rd_q, wb_rd_d, rd_q, rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d, wdata_q, wdata_d, low_q, low_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  mem_size_t         size_q, size_d;
  logic              uns_q, uns_d, store_q, store_d, split_q, split_d;

  logic [OFFW-1:0]     req_off, amask, off;
  logic                illegal, misaligned, crosses;
  logic [ADDR_W-1:0]   beat_addr;
  logic [2*XLEN-1:0]   st_wide, ld_wide;
  logic [2*NBYTES-1:0] st_mbe;
  logic [XLEN-1:0]     ld_data;
  logic [XLEN-1:0]     unused_st_ld;
  logic [2*XLEN-1:0]   unused_ld_wide;
  logic [2*NBYTES-1:0] unused_ld_mbe;

  always_comb begin
    req_off    = req_addr[OFFW-1:0];
    amask      = OFFW'((1 << req_funct3[1:0]) - 1);
    illegal    = (int'(req_funct3[1:0]) > OFFW) || (req_write && req_funct3[2]);
    misaligned = |(req_off & amask);
    crosses    = (int'(req_off) + (1 << req_funct3[1:0])) > NBYTES;
  end

  assign off       = addr_q[OFFW-1:0];
  assign beat_addr = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  // The second beat reads the merge register as the low half of a two-beat window.
  assign ld_wide   = (state_q == ACCESS2) ? {dmem_rdata, low_q} : {{XLEN{1'b0}}, dmem_rdata};

  pipe_lsu_lane_align #(.XLEN(XLEN), .OFFW(OFFW)) u_store_align (
    .off(off), .size(size_q), .uns(1'b0), .st_data(wdata_q),
    .st_wide(st_wide), .st_mbe(st_mbe), .ld_wide('0), .ld_data(unused_st_ld)
  );

  pipe_lsu_lane_align #(.XLEN(XLEN), .OFFW(OFFW)) u_load_align (
    .off(off), .size(size_q), .uns(uns_q), .st_data('0),
    .st_wide(unused_ld_wide), .st_mbe(unused_ld_mbe), .ld_wide(ld_wide), .ld_data(ld_data)
  );

  always_comb begin
    state_d = state_q;
    dmem_read_d = dmem_read_q;
    dmem_write_d = dmem_write_q;
    wb_valid_d = 1'b0;
    fault_d = 1'b0;
    wb_rd_d = wb_rd_q;
    wb_data_d = wb_data_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    size_d = size_q;
    uns_d = uns_q;
    rd_d = rd_q;
    store_d = store_q;
    split_d = split_q;
    low_d = low_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = mem_size_t'(req_funct3[1:0]);
          uns_d   = req_funct3[2];
          rd_d    = req_rd;
          store_d = req_write;
          split_d = SPLIT_EN && crosses;
          if (illegal || (misaligned && !SPLIT_EN)) begin
            fault_d = 1'b1;
          end else begin
            state_d      = ACCESS;
            dmem_read_d  = !req_write;
            dmem_write_d = req_write;
          end
        end
      end
      ACCESS, ACCESS2: begin
        if (dmem_resp) begin
          if (state_q == ACCESS && split_q) begin
            state_d = ACCESS2;
            low_d   = dmem_rdata;
          end else begin
            state_d      = IDLE;
            dmem_read_d  = 1'b0;
            dmem_write_d = 1'b0;
            wb_valid_d   = !store_q;
            if (!store_q) begin
              wb_rd_d   = rd_q;
              wb_data_d = ld_data;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    stall_d     = (state_d != IDLE);
  end

  always_comb begin
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_mbe   = '0;
    if (state_q == ACCESS) begin
      dmem_addr  = beat_addr;
      dmem_wdata = st_wide[XLEN-1:0] & {XLEN{store_q}};
      dmem_mbe   = st_mbe[NBYTES-1:0];
    end else if (state_q == ACCESS2) begin
      dmem_addr  = beat_addr + ADDR_W'(NBYTES);
      dmem_wdata = st_wide[2*XLEN-1:XLEN] & {XLEN{store_q}};
      dmem_mbe   = st_mbe[2*NBYTES-1:NBYTES];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_ready_q <= 1'b1;
      stall_q <= 1'b0;
      dmem_read_q <= 1'b0;
      dmem_write_q <= 1'b0;
      wb_valid_q <= 1'b0;
      fault_q <= 1'b0;
      wb_rd_q <= '0;
      wb_data_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      size_q <= MS_B;
      uns_q <= 1'b0;
      rd_q <= '0;
      store_q <= 1'b0;
      split_q <= 1'b0;
      low_q <= '0;
    end else begin
      state_q <= state_d;
      req_ready_q <= req_ready_d;
      stall_q <= stall_d;
      dmem_read_q <= dmem_read_d;
      dmem_write_q <= dmem_write_d;
      wb_valid_q <= wb_valid_d;
      fault_q <= fault_d;
      wb_rd_q <= wb_rd_d;
      wb_data_q <= wb_data_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      size_q <= size_d;
      uns_q <= uns_d;
      rd_q <= rd_d;
      store_q <= store_d;
      split_q <= split_d;
      low_q <= low_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign stall      = stall_q;
  assign dmem_read  = dmem_read_q;
  assign dmem_write = dmem_write_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_pipe_lsu.sv
// tb/tb_pipe_lsu.sv - directed self-checking bench for pipe_lsu (XLEN=32 and XLEN=64 instances)
module tb_pipe_lsu;
  import pipe_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v32, v64, r_write, resp32, resp64;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [63:0] r_wdata, m_rdata;
  logic [4:0]  r_rd;

  logic        rdy32, rd32, wr32, stall32, wbv32, flt32;
  logic [31:0] addr32, wdata32, wbd32;
  logic [3:0]  mbe32;
  logic [4:0]  wbrd32;

  logic        rdy64, rd64, wr64, stall64, wbv64, flt64;
  logic [31:0] addr64;
  logic [63:0] wdata64, wbd64;
  logic [7:0]  mbe64;
  logic [4:0]  wbrd64;

  int n_err = 0;
  int n_chk = 0;
  int ncyc;

  pipe_lsu #(.XLEN(32), .ADDR_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .req_valid(v32), .req_ready(rdy32), .req_write(r_write),
    .req_funct3(r_f3), .req_addr(r_addr), .req_wdata(r_wdata[31:0]), .req_rd(r_rd),
    .dmem_read(rd32), .dmem_write(wr32), .dmem_addr(addr32), .dmem_wdata(wdata32),
    .dmem_mbe(mbe32), .dmem_resp(resp32), .dmem_rdata(m_rdata[31:0]), .stall(stall32),
    .wb_valid(wbv32), .wb_rd(wbrd32), .wb_data(wbd32), .fault(flt32)
  );

  pipe_lsu #(.XLEN(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .rst(rst), .req_valid(v64), .req_ready(rdy64), .req_write(r_write),
    .req_funct3(r_f3), .req_addr(r_addr), .req_wdata(r_wdata), .req_rd(r_rd),
    .dmem_read(rd64), .dmem_write(wr64), .dmem_addr(addr64), .dmem_wdata(wdata64),
    .dmem_mbe(mbe64), .dmem_resp(resp64), .dmem_rdata(m_rdata), .stall(stall64),
    .wb_valid(wbv64), .wb_rd(wbrd64), .wb_data(wbd64), .fault(flt64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request at a negedge; returns one cycle later with the request accepted.
  task automatic do_req(input bit s64, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [63:0] wd, input logic [4:0] rd);
    r_write = wr; r_f3 = f3; r_addr = addr; r_wdata = wd; r_rd = rd;
    if (s64) v64 = 1'b1; else v32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0; v64 = 1'b0;
  endtask

  // Hold resp low for 'waits' cycles, then pulse it once; counts stall cycles seen.
  task automatic serve(input bit s64, input int waits, input logic [63:0] rdata, output int cnt);
    cnt = 0;
    for (int i = 0; i <= waits; i++) begin
      if (s64 ? stall64 : stall32) cnt++;
      if (i == waits) begin
        m_rdata = rdata;
        if (s64) resp64 = 1'b1; else resp32 = 1'b1;
      end
      @(negedge clk);
    end
    resp32 = 1'b0; resp64 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; v32 = 1'b0; v64 = 1'b0; r_write = 1'b0; r_f3 = 3'b0; r_addr = '0;
    r_wdata = '0; r_rd = '0; resp32 = 1'b0; resp64 = 1'b0; m_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready32", 64'(rdy32), 64'd1);
    chk("rst_ready64", 64'(rdy64), 64'd1);
    chk("rst_stall", 64'(stall32), 64'd0);
    chk("rst_read", 64'(rd32), 64'd0);
    chk("rst_wb_fault", 64'({wbv32, flt32, wr32}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    resp32 = 1'b1; m_rdata = 64'h1111;
    @(negedge clk);
    resp32 = 1'b0;
    chk("idle_resp_wb", 64'(wbv32), 64'd0);
    chk("idle_resp_stall", 64'(stall32), 64'd0);

    // lw x5, 0x100 with three wait cycles
    do_req(1'b0, 1'b0, F3_LW, 32'h100, 64'd0, 5'd5);
    chk("lw_read", 64'(rd32), 64'd1);
    chk("lw_addr", 64'(addr32), 64'h100);
    chk("lw_mbe", 64'(mbe32), 64'hF);
    chk("lw_ready_busy", 64'(rdy32), 64'd0);
    serve(1'b0, 3, 64'hDEADBEEF, ncyc);
    chk("lw_stall_cycles", 64'(ncyc), 64'd4);
    chk("lw_wb_valid", 64'(wbv32), 64'd1);
    chk("lw_wb_rd", 64'(wbrd32), 64'd5);
    chk("lw_wb_data", 64'(wbd32), 64'hDEADBEEF);
    chk("lw_done_read", 64'(rd32), 64'd0);

    // back-to-back lb issued in the wb_valid cycle
    do_req(1'b0, 1'b0, F3_LB, 32'h103, 64'd0, 5'd6);
    chk("lb_wb_pulse_end", 64'(wbv32), 64'd0);
    chk("lb_addr", 64'(addr32), 64'h100);
    chk("lb_mbe", 64'(mbe32), 64'h8);
    serve(1'b0, 0, 64'h80000000, ncyc);
    chk("lb_wb_data", 64'(wbd32), 64'hFFFFFF80);
    chk("lb_wb_rd", 64'(wbrd32), 64'd6);
    do_req(1'b0, 1'b0, F3_LBU, 32'h103, 64'd0, 5'd7);
    serve(1'b0, 0, 64'h80000000, ncyc);
    chk("lbu_wb_data", 64'(wbd32), 64'h00000080);

    // sh 0xABCD to 0x202
    do_req(1'b0, 1'b1, F3_SH, 32'h202, 64'h1234ABCD, 5'd0);
    chk("sh_write", 64'(wr32), 64'd1);
    chk("sh_read", 64'(rd32), 64'd0);
    chk("sh_addr", 64'(addr32), 64'h200);
    chk("sh_mbe", 64'(mbe32), 64'hC);
    chk("sh_wdata", 64'(wdata32), 64'hABCD0000);
    serve(1'b0, 1, 64'd0, ncyc);
    chk("sh_no_wb", 64'(wbv32), 64'd0);
    chk("sh_write_done", 64'(wr32), 64'd0);

    // illegal: ld on XLEN=32, unsigned store
    do_req(1'b0, 1'b0, F3_LD, 32'h100, 64'd0, 5'd1);
    chk("ld32_fault", 64'(flt32), 64'd1);
    chk("ld32_no_strobe", 64'({rd32, stall32}), 64'd0);
    chk("ld32_ready", 64'(rdy32), 64'd1);
    @(negedge clk);
    chk("ld32_fault_pulse", 64'(flt32), 64'd0);
    do_req(1'b0, 1'b1, 3'b100, 32'h100, 64'd0, 5'd1);
    chk("su_fault", 64'(flt32), 64'd1);
    chk("su_no_strobe", 64'(wr32), 64'd0);
    @(negedge clk);

    // misaligned lw 0x101 and lh 0x101
    do_req(1'b0, 1'b0, F3_LW, 32'h101, 64'd0, 5'd9);
`ifndef LSU_MISALIGN_SPLIT_EN
    chk("mis_lw_fault", 64'(flt32), 64'd1);
    chk("mis_lw_no_strobe", 64'({rd32, stall32}), 64'd0);
    @(negedge clk);
    chk("mis_lw_fault_pulse", 64'(flt32), 64'd0);
    do_req(1'b0, 1'b0, F3_LH, 32'h101, 64'd0, 5'd10);
    chk("mis_lh_fault", 64'(flt32), 64'd1);
    chk("mis_lh_no_strobe", 64'(rd32), 64'd0);
    @(negedge clk);
`else
    chk("split_lo_addr", 64'(addr32), 64'h100);
    chk("split_lo_mbe", 64'(mbe32), 64'hE);
    chk("split_no_fault", 64'(flt32), 64'd0);
    resp32 = 1'b1; m_rdata = 64'h44332211;
    @(negedge clk);
    chk("split_hi_addr", 64'(addr32), 64'h104);
    chk("split_hi_mbe", 64'(mbe32), 64'h1);
    chk("split_hi_read", 64'(rd32), 64'd1);
    chk("split_hi_no_wb", 64'(wbv32), 64'd0);
    m_rdata = 64'h88776655;
    @(negedge clk);
    resp32 = 1'b0;
    chk("split_wb_valid", 64'(wbv32), 64'd1);
    chk("split_wb_data", 64'(wbd32), 64'h55443322);
    do_req(1'b0, 1'b0, F3_LH, 32'h101, 64'd0, 5'd10);
    chk("inbeat_lh_no_fault", 64'(flt32), 64'd0);
    chk("inbeat_lh_mbe", 64'(mbe32), 64'h6);
    serve(1'b0, 0, 64'h12800134, ncyc);
    chk("inbeat_lh_data", 64'(wbd32), 64'hFFFF8001);
`endif

    // async reset in the middle of an access
    do_req(1'b0, 1'b0, F3_LW, 32'h100, 64'd0, 5'd3);
    chk("rstmid_read_before", 64'(rd32), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_read_drop", 64'(rd32), 64'd0);
    chk("rstmid_ready", 64'(rdy32), 64'd1);
    chk("rstmid_stall", 64'(stall32), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    resp32 = 1'b1; m_rdata = 64'hCAFE;
    @(negedge clk);
    resp32 = 1'b0;
    chk("rstmid_no_wb", 64'(wbv32), 64'd0);
    @(negedge clk);
    chk("rstmid_no_wb2", 64'(wbv32), 64'd0);

    // XLEN=64
    do_req(1'b1, 1'b0, F3_LD, 32'h8, 64'd0, 5'd11);
    chk("ld64_addr", 64'(addr64), 64'h8);
    chk("ld64_mbe", 64'(mbe64), 64'hFF);
    serve(1'b1, 0, 64'h0123456789ABCDEF, ncyc);
    chk("ld64_wb_data", wbd64, 64'h0123456789ABCDEF);
    chk("ld64_wb_rd", 64'(wbrd64), 64'd11);
    do_req(1'b1, 1'b0, F3_LWU, 32'hC, 64'd0, 5'd12);
    chk("lwu64_addr", 64'(addr64), 64'h8);
    chk("lwu64_mbe", 64'(mbe64), 64'hF0);
    serve(1'b1, 2, 64'h0123456789ABCDEF, ncyc);
    chk("lwu64_wb_data", wbd64, 64'h0000000001234567);
    do_req(1'b1, 1'b0, F3_LW, 32'h8, 64'd0, 5'd13);
    serve(1'b1, 0, 64'h0123456789ABCDEF, ncyc);
    chk("lw64_sext", wbd64, 64'hFFFFFFFF89ABCDEF);
    do_req(1'b1, 1'b1, F3_SW, 32'hC, 64'hCAFEF00D, 5'd0);
    chk("sw64_mbe", 64'(mbe64), 64'hF0);
    chk("sw64_wdata", wdata64, 64'hCAFEF00D00000000);
    serve(1'b1, 0, 64'd0, ncyc);
    chk("sw64_no_wb", 64'(wbv64), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
